// File: rtl/clip_controller.sv
// Two-clip record/playback sequencer: sole master of the single-port sample RAM,
// writing mic samples on record and streaming them to the audio path on playback.
module clip_controller #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 12
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              record,
  input  logic              play,
  input  logic              clipselectionwr,
  input  logic              clipselectionr,
  input  logic              sample_tick,
  input  logic [DATA_W-1:0] mic_sample,
  output logic [ADDR_W:0]   mem_addr,
  output logic              mem_we,
  output logic              mem_re,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] audio_out,
  output logic              audio_valid,
  output logic              recording,
  output logic              playing
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RECORD = 2'd1;
  localparam logic [1:0] S_PLAY   = 2'd2;

  localparam logic [ADDR_W:0] CLIP_DEPTH = {1'b1, {ADDR_W{1'b0}}};

  logic [1:0]            state_q, state_d;
  logic                  record_d_q, play_d_q;
  logic                  wr_clip_q, wr_clip_d;
  logic                  rd_clip_q, rd_clip_d;
  logic [ADDR_W-1:0]     offset_q, offset_d;
  logic [1:0][ADDR_W:0]  len_q, len_d;
  logic [ADDR_W:0]       mem_addr_q, mem_addr_d;
  logic                  mem_we_q, mem_we_d;
  logic                  mem_re_q, mem_re_d;
  logic [DATA_W-1:0]     mem_wdata_q, mem_wdata_d;
  logic                  rd_pend_q;
  logic [DATA_W-1:0]     audio_out_q;
  logic                  audio_valid_q;

  logic rec_edge, play_edge, last_rd;

  assign rec_edge  = record & ~record_d_q;
  assign play_edge = play & ~play_d_q;
  assign last_rd   = (({1'b0, offset_q} + (ADDR_W+1)'(1)) == len_q[rd_clip_q]);

  always_comb begin
    state_d     = state_q;
    wr_clip_d   = wr_clip_q;
    rd_clip_d   = rd_clip_q;
    offset_d    = offset_q;
    len_d       = len_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    mem_re_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rec_edge) begin
          state_d   = S_RECORD;
          wr_clip_d = clipselectionwr;
          offset_d  = '0;
        end else if (play_edge && (len_q[clipselectionr] != '0)) begin
          state_d   = S_PLAY;
          rd_clip_d = clipselectionr;
          offset_d  = '0;
        end
      end
      S_RECORD: begin
        // A stop press outranks a coincident tick: that sample is dropped.
        if (rec_edge) begin
          len_d[wr_clip_q] = {1'b0, offset_q};
          state_d          = S_IDLE;
        end else if (sample_tick) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = {wr_clip_q, offset_q};
          mem_wdata_d = mic_sample;
          offset_d    = offset_q + ADDR_W'(1);
          if (&offset_q) begin
            len_d[wr_clip_q] = CLIP_DEPTH;
            state_d          = S_IDLE;
          end
        end
      end
      S_PLAY: begin
        if (play_edge) begin
          state_d = S_IDLE;
        end else if (sample_tick) begin
          mem_re_d   = 1'b1;
          mem_addr_d = {rd_clip_q, offset_q};
          offset_d   = offset_q + ADDR_W'(1);
          if (last_rd) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      // Held high so a button still pressed as reset releases is not an edge.
      record_d_q    <= 1'b1;
      play_d_q      <= 1'b1;
      wr_clip_q     <= 1'b0;
      rd_clip_q     <= 1'b0;
      offset_q      <= '0;
      len_q         <= '0;
      mem_addr_q    <= '0;
      mem_we_q      <= 1'b0;
      mem_re_q      <= 1'b0;
      mem_wdata_q   <= '0;
      rd_pend_q     <= 1'b0;
      audio_out_q   <= '0;
      audio_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      record_d_q    <= record;
      play_d_q      <= play;
      wr_clip_q     <= wr_clip_d;
      rd_clip_q     <= rd_clip_d;
      offset_q      <= offset_d;
      len_q         <= len_d;
      mem_addr_q    <= mem_addr_d;
      mem_we_q      <= mem_we_d;
      mem_re_q      <= mem_re_d;
      mem_wdata_q   <= mem_wdata_d;
      rd_pend_q     <= mem_re_q;
      audio_valid_q <= rd_pend_q;
      if (rd_pend_q) audio_out_q <= mem_rdata;
    end
  end

  assign mem_addr    = mem_addr_q;
  assign mem_we      = mem_we_q;
  assign mem_re      = mem_re_q;
  assign mem_wdata   = mem_wdata_q;
  assign audio_out   = audio_out_q;
  assign audio_valid = audio_valid_q;
  assign recording   = (state_q == S_RECORD);
  assign playing     = (state_q == S_PLAY);

endmodule

// File: tb/tb_clip_controller.sv
// Scoreboard bench for clip_controller (ADDR_W=3): stimulus queues expected memory
// and audio events, a negedge monitor pops and compares them as the DUT emits them.
module tb_clip_controller;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic record = 1'b0, play = 1'b0;
  logic clipselectionwr = 1'b0, clipselectionr = 1'b0;
  logic sample_tick = 1'b0;
  logic [DATA_W-1:0] mic_sample = '0;
  logic [ADDR_W:0]   mem_addr;
  logic              mem_we, mem_re;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic [DATA_W-1:0] audio_out;
  logic              audio_valid, recording, playing;

  clip_controller #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clock(clk), .reset(reset), .record(record), .play(play),
    .clipselectionwr(clipselectionwr), .clipselectionr(clipselectionr),
    .sample_tick(sample_tick), .mic_sample(mic_sample),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_re(mem_re),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .audio_out(audio_out), .audio_valid(audio_valid),
    .recording(recording), .playing(playing)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous sample RAM
  logic [DATA_W-1:0] mem [0:(1<<(ADDR_W+1))-1];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  typedef struct {
    logic [ADDR_W:0]   addr;
    logic [DATA_W-1:0] data;
    int                cyc;
  } ev_t;

  ev_t wq[$];
  ev_t rq[$];
  ev_t aq[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: event with nothing expected, addr 0x%0h wdata 0x%0h audio 0x%0h (cycle %0d)",
             name, mem_addr, mem_wdata, audio_out, cyc);
  endtask

  // Monitor
  always @(negedge clk) begin
    ev_t e;
    if (mem_we && mem_re) unexpected("we_and_re");
    if (mem_we) begin
      if (wq.size() == 0) unexpected("write");
      else begin
        e = wq.pop_front();
        check("write_addr", 32'(mem_addr), 32'(e.addr));
        check("write_data", 32'(mem_wdata), 32'(e.data));
        check("write_cycle", cyc, e.cyc);
        $display("write addr 0x%0h data 0x%0h cycle %0d", mem_addr, mem_wdata, cyc);
      end
    end
    if (mem_re) begin
      if (rq.size() == 0) unexpected("read");
      else begin
        e = rq.pop_front();
        check("read_addr", 32'(mem_addr), 32'(e.addr));
        check("read_cycle", cyc, e.cyc);
        $display("read  addr 0x%0h cycle %0d", mem_addr, cyc);
      end
    end
    if (audio_valid) begin
      if (aq.size() == 0) unexpected("audio");
      else begin
        e = aq.pop_front();
        check("audio_data", 32'(audio_out), 32'(e.data));
        check("audio_cycle", cyc, e.cyc);
        $display("audio data 0x%0h cycle %0d", audio_out, cyc);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Tick issued now (cycle cyc); optional expected write/read+audio events.
  task automatic do_tick(input logic [DATA_W-1:0] smp, input bit exp_w, input bit exp_r,
                         input logic [ADDR_W:0] addr, input logic [DATA_W-1:0] rd_data);
    ev_t e;
    mic_sample  = smp;
    sample_tick = 1'b1;
    if (exp_w) begin
      e.addr = addr; e.data = smp; e.cyc = cyc + 1; wq.push_back(e);
    end
    if (exp_r) begin
      e.addr = addr; e.data = '0; e.cyc = cyc + 1; rq.push_back(e);
      e.data = rd_data; e.cyc = cyc + 3; aq.push_back(e);
    end
    step(1);
    sample_tick = 1'b0;
    step(3);
  endtask

  task automatic press_rec();
    record = 1'b1; step(1); record = 1'b0;
  endtask

  task automatic press_play();
    play = 1'b1; step(1); play = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_addr"}, 32'(mem_addr), 32'h0);
    check({tag, "_strobes"}, {29'h0, mem_we, mem_re, audio_valid}, 32'h0);
    check({tag, "_wdata"}, 32'(mem_wdata), 32'h0);
    check({tag, "_audio"}, 32'(audio_out), 32'h0);
    check({tag, "_status"}, {30'h0, recording, playing}, 32'h0);
  endtask

  initial begin
    // Reset with record held: releasing reset must not start a recording
    reset = 1'b0; record = 1'b1;
    step(3);
    check_reset_outputs("reset");
    reset = 1'b1;
    step(1);
    check("held_rec_no_trigger", 32'(recording), 32'h0);
    record = 1'b0;
    step(1);

    // Play of an empty clip: no state change, no strobes
    clipselectionr = 1'b1;
    press_play();
    check("empty_play_playing", 32'(playing), 32'h0);
    do_tick(8'hAA, 0, 0, '0, '0);

    // Record clip 0, switch changes and play presses ignored meanwhile
    clipselectionwr = 1'b0;
    press_rec();
    check("rec0_recording", 32'(recording), 32'h1);
    clipselectionwr = 1'b1;
    press_play();
    check("rec0_play_ignored", {30'h0, recording, playing}, 32'h2);
    for (int i = 0; i < 5; i++) do_tick(8'h10 + 8'(i), 1, 0, 4'(i), '0);
    press_rec();
    check("rec0_stopped", 32'(recording), 32'h0);

    // Play clip 0: 5 reads then self-stop
    clipselectionr = 1'b0;
    press_play();
    check("play0_playing", 32'(playing), 32'h1);
    for (int i = 0; i < 5; i++) begin
      do_tick('0, 0, 1, 4'(i), 8'h10 + 8'(i));
      if (i == 3) check("play0_still_playing", 32'(playing), 32'h1);
    end
    check("play0_done", 32'(playing), 32'h0);

    // Record clip 1 for 10 ticks: auto-stop after the 8th
    clipselectionwr = 1'b1;
    press_rec();
    for (int i = 0; i < 10; i++) begin
      do_tick(8'h20 + 8'(i), (i < 8), 0, 4'(8 + i), '0);
      if (i == 6) check("rec1_still_recording", 32'(recording), 32'h1);
    end
    check("rec1_autostop", 32'(recording), 32'h0);

    // Clip 0 length untouched: 6 ticks give exactly 5 reads
    clipselectionr = 1'b0;
    press_play();
    for (int i = 0; i < 6; i++) do_tick('0, 0, (i < 5), 4'(i), 8'h10 + 8'(i));
    check("replay0_done", 32'(playing), 32'h0);

    // Clip 1 full length 8, stopped early by play press after 2 reads
    clipselectionr = 1'b1;
    press_play();
    for (int i = 0; i < 2; i++) do_tick('0, 0, 1, 4'(8 + i), 8'h20 + 8'(i));
    press_play();
    check("play1_stop_press", 32'(playing), 32'h0);
    do_tick('0, 0, 0, '0, '0);

    // Clip 1 plays all 8 samples
    press_play();
    for (int i = 0; i < 9; i++) do_tick('0, 0, (i < 8), 4'(8 + i), 8'h20 + 8'(i));
    check("play1_full_done", 32'(playing), 32'h0);

    // Record and play edges together: record wins
    clipselectionwr = 1'b0;
    record = 1'b1; play = 1'b1;
    step(1);
    record = 1'b0; play = 1'b0;
    check("both_edges", {30'h0, recording, playing}, 32'h2);
    for (int i = 0; i < 3; i++) do_tick(8'h30 + 8'(i), 1, 0, 4'(i), '0);
    // Stop coincident with tick at offset 3: no write
    record = 1'b1; sample_tick = 1'b1; mic_sample = 8'hEE;
    step(1);
    record = 1'b0; sample_tick = 1'b0;
    check("stop_tick_recording", 32'(recording), 32'h0);
    step(3);
    clipselectionr = 1'b0;
    press_play();
    for (int i = 0; i < 4; i++) do_tick('0, 0, (i < 3), 4'(i), 8'h30 + 8'(i));
    check("len3_done", 32'(playing), 32'h0);

    // Reset during play of clip 1 at offset 2
    clipselectionr = 1'b1;
    press_play();
    for (int i = 0; i < 2; i++) do_tick('0, 0, 1, 4'(8 + i), 8'h20 + 8'(i));
    reset = 1'b0;
    step(1);
    check_reset_outputs("midreset");
    reset = 1'b1;
    step(1);
    press_play();
    check("after_reset_play", 32'(playing), 32'h0);
    do_tick('0, 0, 0, '0, '0);

    step(5);
    check("wq_empty", wq.size(), 0);
    check("rq_empty", rq.size(), 0);
    check("aq_empty", aq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
